// File: rtl/mul_iter_unit.sv
// Iterative radix-2^BPC shift-add integer multiplier (MUL / MULH / MULHU) with sign fix-up.
// Latency: WIDTH/BPC+2 cycles from accept to out_valid (shorter with MUL_EARLY_OUT_EN defined).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or DONE&out_ready, never during flush.
module mul_iter_unit #(
    parameter int WIDTH = 32,
    parameter int BPC   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mul_op,
    input  logic [WIDTH-1:0] alu_src1,
    input  logic [WIDTH-1:0] alu_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mul_result,
    output logic             busy
);

    localparam int N  = WIDTH / BPC;
    localparam int AW = 2 * WIDTH;
    localparam int CW = $clog2(N + 1);
    localparam int SW = $clog2(AW);

    // Elaboration-time guard against unsupported geometries.
    generate
        if ((WIDTH < 8) || (WIDTH % 2 != 0) || (WIDTH % BPC != 0) ||
            !((BPC == 1) || (BPC == 2) || (BPC == 4))) begin : g_bad_param
            $error("mul_iter_unit: unsupported WIDTH/BPC combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Operation context captured at accept.
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_neg;
    logic [AW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;

    logic             w_accept;
    logic             w_signed_in;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic             w_neg_in;
    logic             w_skip_calc;
    logic [BPC-1:0]   w_digit;
    logic [AW-1:0]    w_partial;
    logic [SW-1:0]    w_shamt;
    logic [AW-1:0]    w_shifted;
    logic [WIDTH-1:0] w_mplier_nxt;
    logic             w_calc_last;
    logic [AW-1:0]    w_acc_fix;
    logic [WIDTH-1:0] w_sel;

    // Operand conditioning: signedness from the op, magnitudes, result sign.
    always_comb begin
        w_signed_in = mul_op[0] | mul_op[1];
        w_mag1      = (w_signed_in && alu_src1[WIDTH-1]) ? -alu_src1 : alu_src1;
        w_mag2      = (w_signed_in && alu_src2[WIDTH-1]) ? -alu_src2 : alu_src2;
        w_neg_in    = w_signed_in & (alu_src1[WIDTH-1] ^ alu_src2[WIDTH-1]);
`ifdef MUL_EARLY_OUT_EN
        // A zero multiplier contributes nothing: go straight to sign fix-up.
        w_skip_calc = (w_mag2 == '0);
`else
        w_skip_calc = 1'b0;
`endif
    end

    // One CALC step: partial product of the low multiplier digit, aligned by digit position.
    always_comb begin
        w_digit      = r_mplier[BPC-1:0];
        w_partial    = {{WIDTH{1'b0}}, r_mcand} * {{(AW-BPC){1'b0}}, w_digit};
        w_shamt      = SW'(r_cnt) * SW'(BPC);
        w_shifted    = w_partial << w_shamt;
        w_mplier_nxt = r_mplier >> BPC;
`ifdef MUL_EARLY_OUT_EN
        // Stop once no multiplier bits remain; the skipped digits are all zero.
        w_calc_last  = (r_cnt == CW'(N - 1)) || (w_mplier_nxt == '0);
`else
        w_calc_last  = (r_cnt == CW'(N - 1));
`endif
    end

    // Sign fix-up and result select computed from the final magnitude product.
    always_comb begin
        w_acc_fix = r_neg ? -r_acc : r_acc;
        case (r_op)
            3'b001:  w_sel = w_acc_fix[WIDTH-1:0];
            3'b010:  w_sel = w_acc_fix[AW-1:WIDTH];
            3'b100:  w_sel = w_acc_fix[AW-1:WIDTH];
            default: w_sel = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; flush wins over everything but reset.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = (r_state != S_IDLE);
        w_accept    = 1'b0;

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase

        if (flush) begin
            in_ready = 1'b0;
        end
        w_accept = in_valid & in_ready;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_skip_calc ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (w_calc_last) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_skip_calc ? S_FIX : S_CALC;
                end else if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Datapath: capture on accept, accumulate in CALC, fix sign and register result in FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (flush) begin
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_op     <= mul_op;
            r_mcand  <= w_mag1;
            r_mplier <= w_mag2;
            r_neg    <= w_neg_in;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_CALC) begin
            r_acc    <= r_acc + w_shifted;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= r_cnt + 1'b1;
        end else if (r_state == S_FIX) begin
            r_acc    <= w_acc_fix;
            r_result <= w_sel;
        end
    end

    assign mul_result = r_result;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed bench for mul_iter_unit (WIDTH=32, BPC=2): results, latency, hold, back-to-back, flush, reset.
// Latency expectations follow MUL_EARLY_OUT_EN when the bench is built with it defined.
// Result consumer is normally always ready; out_ready is dropped only for the hold test.
module tb_mul_iter_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  mul_op;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] mul_result;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    mul_iter_unit #(.WIDTH(32), .BPC(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mul_op     (mul_op),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mul_result (mul_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected accept-to-out_valid latency in cycles.
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
`ifdef MUL_EARLY_OUT_EN
        logic [31:0] m;
        int msb;
        m = ((op[0] | op[1]) && b[31]) ? -b : b;
        if (m == 32'd0) return 2;
        msb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) msb = i;
        return 2 + (msb + 2) / 2;
`else
        return 18;
`endif
    endfunction

    // Present one op; returns #1 after the accept edge (cycle 1 of the op).
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mul_op   = op;
        alu_src1 = a;
        alu_src2 = b;
        in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mul_op   = 3'b000;
        alu_src1 = 32'hDEAD_BEEF;
        alu_src2 = 32'hCAFE_F00D;
    endtask

    // Wait (bounded) for out_valid, check latency and result, then step past the retiring edge.
    task automatic wait_check(input string tag, input logic [31:0] exp_res, input int lat);
        int  cyc;
        bit  seen;
        cyc  = 1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            cyc++;
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_lat"}, 32'(cyc), 32'(lat));
        chk({tag, "_res"}, mul_result, exp_res);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit rose;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mul_op    = 3'b000;
        alu_src1  = '0;
        alu_src2  = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", mul_result, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Main results.
        issue("t1", 3'b001, 32'd3, 32'hFFFF_FFFB);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_check("t1", 32'hFFFF_FFF1, exp_lat(3'b001, 32'hFFFF_FFFB));

        issue("t2a", 3'b010, 32'h8000_0000, 32'h8000_0000);
        wait_check("t2a", 32'h4000_0000, exp_lat(3'b010, 32'h8000_0000));

        issue("t2b", 3'b010, 32'hFFFF_FFFF, 32'd2);
        wait_check("t2b", 32'hFFFF_FFFF, exp_lat(3'b010, 32'd2));

        issue("t3a", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_check("t3a", 32'hFFFF_FFFE, exp_lat(3'b100, 32'hFFFF_FFFF));

        issue("t3b", 3'b011, 32'd5, 32'd6);
        wait_check("t3b", 32'd0, exp_lat(3'b011, 32'd6));

        issue("t3c", 3'b001, 32'h1234_5678, 32'h0000_0010);
        wait_check("t3c", 32'h2345_6780, exp_lat(3'b001, 32'h0000_0010));

        issue("t3d", 3'b100, 32'h8000_0000, 32'd4);
        wait_check("t3d", 32'd2, exp_lat(3'b100, 32'd4));

        // Hold in DONE while out_ready is low, then retire and accept on the same edge.
        out_ready = 1'b0;
        issue("t4", 3'b001, 32'd6, 32'd7);
        wait_check("t4", 32'd42, exp_lat(3'b001, 32'd7));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_hold_vld", 32'(out_valid), 32'd1);
            chk("t4_hold_res", mul_result, 32'd42);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue("t4_b2b", 3'b001, 32'd9, 32'd9);
        chk("t4_b2b_vld_drop", 32'(out_valid), 32'd0);
        chk("t4_b2b_busy", 32'(busy), 32'd1);
        wait_check("t4_b2b", 32'd81, exp_lat(3'b001, 32'd9));

        // Flush during CALC cycle 7.
        issue("t5f", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (6) @(posedge clk);
        #1;
        chk("t5f_busy_pre", 32'(busy), 32'd1);
        flush = 1'b1;
        #1;
        chk("t5f_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("t5f_busy", 32'(busy), 32'd0);
        chk("t5f_out_valid", 32'(out_valid), 32'd0);

        // Flush beats a simultaneous accept in IDLE.
        mul_op   = 3'b001;
        alu_src1 = 32'd2;
        alu_src2 = 32'd3;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        chk("t5f_acc_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("t5f_acc_busy", 32'(busy), 32'd0);
        rose = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        chk("t5f_never_valid", 32'(rose), 32'd0);

        // Reset while in FIX (cycle 17).
        issue("t5r", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (16) @(posedge clk);
        #1;
        chk("t5r_busy_fix", 32'(busy), 32'd1);
        chk("t5r_vld_fix", 32'(out_valid), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5r_out_valid", 32'(out_valid), 32'd0);
        chk("t5r_result", mul_result, 32'd0);
        chk("t5r_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        chk("t5r_in_ready", 32'(in_ready), 32'd1);

        // Small multipliers (early-out latencies when enabled).
        issue("t6a", 3'b001, 32'd7, 32'd1);
        wait_check("t6a", 32'd7, exp_lat(3'b001, 32'd1));

        issue("t6b", 3'b001, 32'h0000_1234, 32'd0);
        wait_check("t6b", 32'd0, exp_lat(3'b001, 32'd0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
